// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared widths, FSM encoding and strobe helpers for the SRAM arbiter.
package sram_arbiter_pkg;
   localparam int ADDR_W = 18;
   localparam int DATA_W = 16;
   localparam int PORT_W = 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RECOVER = 2'd2
   } state_t;

   // Active-low SRAM control strobes, kept together so they update as one register.
   typedef struct packed {
      logic cs;
      logic we;
      logic oe;
      logic ub;
      logic lb;
   } strobe_t;

   localparam strobe_t STROBE_IDLE = '1;

   function automatic strobe_t access_strobe(input logic write, input logic [1:0] mask);
      return '{cs: 1'b0, we: ~write, oe: write, ub: write & ~mask[1], lb: write & ~mask[0]};
   endfunction
endpackage

// File: rtl/sram_rr_grant.sv
// sram_rr_grant: two-requester round-robin grant; the last-grant pointer moves only on acceptance.
module sram_rr_grant (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   input  logic       accept,
   output logic [1:0] grant
);
   logic last;

   always_comb begin
      grant[0] = valid[0] & (~valid[1] | last);
      grant[1] = valid[1] & (~valid[0] | ~last);
   end

   // Reset points at port1 so port0 wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) last <= 1'b1;
      else if (accept) last <= grant[1];
   end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter driving an asynchronous 16-bit SRAM
// with registered strobes, programmable wait states and a one-cycle recovery phase.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic              io_mainClk,
   input  logic              io_asyncReset,
   input  logic              io_p0_valid,
   output logic              io_p0_ready,
   input  logic              io_p0_write,
   input  logic [ADDR_W-1:0] io_p0_addr,
   input  logic [DATA_W-1:0] io_p0_wdata,
   input  logic [1:0]        io_p0_mask,
   output logic              io_p0_rsp_valid,
   output logic [DATA_W-1:0] io_p0_rdata,
   input  logic              io_p1_valid,
   output logic              io_p1_ready,
   input  logic              io_p1_write,
   input  logic [ADDR_W-1:0] io_p1_addr,
   input  logic [DATA_W-1:0] io_p1_wdata,
   input  logic [1:0]        io_p1_mask,
   output logic              io_p1_rsp_valid,
   output logic [DATA_W-1:0] io_p1_rdata,
   output logic [ADDR_W-1:0] io_sram_addr,
   input  logic [DATA_W-1:0] io_sram_dat_read,
   output logic [DATA_W-1:0] io_sram_dat_write,
   output logic              io_sram_dat_writeEnable,
   output logic              io_sram_cs,
   output logic              io_sram_we,
   output logic              io_sram_oe,
   output logic              io_sram_ub,
   output logic              io_sram_lb
);
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t            state;
   logic [3:0]        cnt;
   logic [PORT_W-1:0] owner;
   logic              wr;
   strobe_t           strb;
   logic [1:0]        grant;
   logic              accept;
   logic              sel;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [1:0]        sel_mask;

   sram_rr_grant u_grant (
      .clk   (io_mainClk),
      .rst   (io_asyncReset),
      .valid ({io_p1_valid, io_p0_valid}),
      .accept(accept),
      .grant (grant)
   );

   always_comb begin
      io_p0_ready = (state == IDLE) & grant[0];
      io_p1_ready = (state == IDLE) & grant[1];
      accept      = io_p0_ready | io_p1_ready;
      sel         = grant[1];
      sel_write   = sel ? io_p1_write : io_p0_write;
      sel_addr    = sel ? io_p1_addr  : io_p0_addr;
      sel_wdata   = sel ? io_p1_wdata : io_p0_wdata;
      sel_mask    = sel ? io_p1_mask  : io_p0_mask;
   end

   assign io_sram_cs = strb.cs;
   assign io_sram_we = strb.we;
   assign io_sram_oe = strb.oe;
   assign io_sram_ub = strb.ub;
   assign io_sram_lb = strb.lb;

   always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
      if (io_asyncReset) begin
         state                   <= IDLE;
         cnt                     <= '0;
         owner                   <= '0;
         wr                      <= 1'b0;
         strb                    <= STROBE_IDLE;
         io_sram_addr            <= '0;
         io_sram_dat_write       <= '0;
         io_sram_dat_writeEnable <= 1'b0;
         io_p0_rdata             <= '0;
         io_p1_rdata             <= '0;
         io_p0_rsp_valid         <= 1'b0;
         io_p1_rsp_valid         <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               state                   <= ACCESS;
               cnt                     <= WAIT_INIT;
               owner                   <= sel;
               wr                      <= sel_write;
               strb                    <= access_strobe(sel_write, sel_mask);
               io_sram_addr            <= sel_addr;
               io_sram_dat_writeEnable <= sel_write;
               if (sel_write) io_sram_dat_write <= sel_wdata;
            end
            ACCESS: if (cnt == 4'd0) begin
               state           <= RECOVER;
               strb            <= STROBE_IDLE;
               io_p0_rsp_valid <= ~owner[0];
               io_p1_rsp_valid <= owner[0];
               if (!wr && !owner[0]) io_p0_rdata <= io_sram_dat_read;
               if (!wr && owner[0]) io_p1_rdata <= io_sram_dat_read;
            end else begin
               cnt <= cnt - 4'd1;
            end
            // Write data stays driven through this cycle for hold after we rises.
            RECOVER: begin
               state                   <= IDLE;
               io_p0_rsp_valid         <= 1'b0;
               io_p1_rsp_valid         <= 1'b0;
               io_sram_dat_writeEnable <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed table-driven bench for sram_arbiter at WAIT_CYCLES 1, 0 and 15.
module tb_sram_arbiter;
   typedef struct {
      logic        port;
      logic        write;
      logic [17:0] addr;
      logic [15:0] wdata;
      logic [1:0]  mask;
      logic [15:0] rd;
      logic        ub, lb, oe, we;
      logic [15:0] rdata0, rdata1;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        p0v, p0w, p1v, p1w;
   logic [17:0] p0a, p1a;
   logic [15:0] p0d, p1d, dat_rd;
   logic [1:0]  p0m, p1m;
   logic        r0, r1, rv0, rv1, wen, cs, we, oe, ub, lb;
   logic [15:0] rd0, rd1, dw;
   logic [17:0] sa;

   logic        xv[2], xr[2], xrv[2], xr1[2], xrv1[2], xwen[2], xcs[2], xwe[2], xoe[2], xub[2], xlb[2];
   logic [15:0] xrd[2], xrd1[2], xdw[2];
   logic [17:0] xa[2];

   int checks = 0;
   int errors = 0;
   vec_t vecs[7];

   sram_arbiter #(.WAIT_CYCLES(1)) dut (
      .io_mainClk(clk), .io_asyncReset(rst),
      .io_p0_valid(p0v), .io_p0_ready(r0), .io_p0_write(p0w), .io_p0_addr(p0a),
      .io_p0_wdata(p0d), .io_p0_mask(p0m), .io_p0_rsp_valid(rv0), .io_p0_rdata(rd0),
      .io_p1_valid(p1v), .io_p1_ready(r1), .io_p1_write(p1w), .io_p1_addr(p1a),
      .io_p1_wdata(p1d), .io_p1_mask(p1m), .io_p1_rsp_valid(rv1), .io_p1_rdata(rd1),
      .io_sram_addr(sa), .io_sram_dat_read(dat_rd), .io_sram_dat_write(dw),
      .io_sram_dat_writeEnable(wen), .io_sram_cs(cs), .io_sram_we(we), .io_sram_oe(oe),
      .io_sram_ub(ub), .io_sram_lb(lb)
   );

   for (genvar g = 0; g < 2; g++) begin : gx
      sram_arbiter #(.WAIT_CYCLES(g == 0 ? 0 : 15)) dut_x (
         .io_mainClk(clk), .io_asyncReset(rst),
         .io_p0_valid(xv[g]), .io_p0_ready(xr[g]), .io_p0_write(1'b0), .io_p0_addr(p0a),
         .io_p0_wdata(p0d), .io_p0_mask(p0m), .io_p0_rsp_valid(xrv[g]), .io_p0_rdata(xrd[g]),
         .io_p1_valid(1'b0), .io_p1_ready(xr1[g]), .io_p1_write(1'b0), .io_p1_addr(18'h0),
         .io_p1_wdata(16'h0), .io_p1_mask(2'b00), .io_p1_rsp_valid(xrv1[g]), .io_p1_rdata(xrd1[g]),
         .io_sram_addr(xa[g]), .io_sram_dat_read(dat_rd), .io_sram_dat_write(xdw[g]),
         .io_sram_dat_writeEnable(xwen[g]), .io_sram_cs(xcs[g]), .io_sram_we(xwe[g]),
         .io_sram_oe(xoe[g]), .io_sram_ub(xub[g]), .io_sram_lb(xlb[g])
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One single-requester transaction on the WAIT_CYCLES=1 instance.
   task automatic txn(input int idx, input vec_t v);
      int cs_n = 0, we_n = 0, rsp_n = 0, rsp_k = 0, rsp_other = 0;
      logic s_ub = 1'b1, s_lb = 1'b1, s_oe = 1'b1, s_we = 1'b1, s_wen = 1'b0, rec_wen = 1'b0;
      logic [17:0] s_addr = '0;
      logic [15:0] s_dw = '0;
      dat_rd = 16'hDEAD;
      if (v.port) begin
         p1v = 1'b1; p1w = v.write; p1a = v.addr; p1d = v.wdata; p1m = v.mask;
      end else begin
         p0v = 1'b1; p0w = v.write; p0a = v.addr; p0d = v.wdata; p0m = v.mask;
      end
      #1;
      chk($sformatf("v%0d ready", idx), {r1, r0}, v.port ? 2'b10 : 2'b01);
      @(negedge clk);
      for (int k = 1; k <= 6; k++) begin
         if (k == 1) begin
            p0v = 1'b0; p1v = 1'b0;
            s_ub = ub; s_lb = lb; s_oe = oe; s_we = we; s_wen = wen; s_addr = sa; s_dw = dw;
         end
         dat_rd = (k == 2) ? v.rd : 16'hDEAD;
         if (!cs) cs_n++;
         if (!we) we_n++;
         if (v.port ? rv1 : rv0) begin
            rsp_n++; rsp_k = k; rec_wen = wen;
         end
         if (v.port ? rv0 : rv1) rsp_other++;
         @(negedge clk);
      end
      chk($sformatf("v%0d addr", idx), s_addr, v.addr);
      chk($sformatf("v%0d ub/lb/oe/we", idx), {s_ub, s_lb, s_oe, s_we}, {v.ub, v.lb, v.oe, v.we});
      chk($sformatf("v%0d wen access", idx), s_wen, v.write);
      if (v.write) chk($sformatf("v%0d dat_write", idx), s_dw, v.wdata);
      chk($sformatf("v%0d cs low cycles", idx), cs_n, 2);
      chk($sformatf("v%0d we low cycles", idx), we_n, v.write ? 2 : 0);
      chk($sformatf("v%0d rsp count", idx), rsp_n, 1);
      chk($sformatf("v%0d rsp cycle", idx), rsp_k, 3);
      chk($sformatf("v%0d other rsp", idx), rsp_other, 0);
      chk($sformatf("v%0d wen recover", idx), rec_wen, v.write);
      chk($sformatf("v%0d rdata0", idx), rd0, v.rdata0);
      chk($sformatf("v%0d rdata1", idx), rd1, v.rdata1);
   endtask

   // Read on an alternate-wait instance; data is only correct during the last ACCESS cycle.
   task automatic rd_len(input int i, input int w, input logic [17:0] addr, input logic [15:0] rd);
      int cs_n = 0, oe_n = 0, rsp_n = 0, rsp_k = 0;
      dat_rd = 16'hDEAD;
      p0a = addr;
      xv[i] = 1'b1;
      #1;
      chk($sformatf("w%0d ready", w), xr[i], 1'b1);
      @(negedge clk);
      xv[i] = 1'b0;
      for (int k = 1; k <= w + 4; k++) begin
         dat_rd = (k == w + 1) ? rd : 16'hDEAD;
         if (!xcs[i]) cs_n++;
         if (!xoe[i]) oe_n++;
         if (xrv[i]) begin
            rsp_n++; rsp_k = k;
         end
         @(negedge clk);
      end
      chk($sformatf("w%0d cs low cycles", w), cs_n, w + 1);
      chk($sformatf("w%0d oe low cycles", w), oe_n, w + 1);
      chk($sformatf("w%0d rsp count", w), rsp_n, 1);
      chk($sformatf("w%0d rsp cycle", w), rsp_k, w + 2);
      chk($sformatf("w%0d rdata", w), xrd[i], rd);
      chk($sformatf("w%0d addr", w), xa[i], addr);
   endtask

   initial begin
      int both, nready, cnt;
      int acc_t[4], acc_p[4];
      vecs[0] = '{1'b0, 1'b0, 18'h00010, 16'h0000, 2'b11, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000};
      vecs[1] = '{1'b1, 1'b1, 18'h3FFFF, 16'hABCD, 2'b10, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000};
      vecs[2] = '{1'b1, 1'b0, 18'h00ABC, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'hBEEF};
      vecs[3] = '{1'b0, 1'b1, 18'h12345, 16'h5A5A, 2'b11, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'hBEEF};
      vecs[4] = '{1'b0, 1'b1, 18'h00001, 16'hFFFF, 2'b00, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1234, 16'hBEEF};
      vecs[5] = '{1'b1, 1'b1, 18'h2AAAA, 16'h00C3, 2'b01, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 16'hBEEF};
      vecs[6] = '{1'b0, 1'b0, 18'h20000, 16'h0000, 2'b00, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0F0F, 16'hBEEF};
      rst = 1'b1;
      p0v = 0; p0w = 0; p0a = '0; p0d = '0; p0m = '0;
      p1v = 0; p1w = 0; p1a = '0; p1d = '0; p1m = '0;
      dat_rd = 16'hDEAD;
      xv[0] = 1'b0; xv[1] = 1'b0;
      #12;
      chk("reset strobes", {cs, we, oe, ub, lb}, 5'b11111);
      chk("reset wen", wen, 1'b0);
      chk("reset addr", sa, 18'h0);
      chk("reset dat_write", dw, 16'h0);
      chk("reset rdata", {rd0, rd1}, 32'h0);
      chk("reset rsp", {rv0, rv1}, 2'b00);
      chk("reset ready", {r0, r1}, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 7; i++) txn(i, vecs[i]);
      // Reset in the 2nd ACCESS cycle of a write.
      p0v = 1'b1; p0w = 1'b1; p0a = 18'h00555; p0d = 16'h1111; p0m = 2'b11;
      @(negedge clk);
      p0v = 1'b0;
      chk("abort cs/we in access", {cs, we, wen}, 3'b001);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort strobes async", {cs, we, oe, ub, lb}, 5'b11111);
      chk("abort wen async", wen, 1'b0);
      chk("abort addr", sa, 18'h0);
      chk("abort rdata", {rd0, rd1}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         if (rv0 | rv1) cnt++;
         @(negedge clk);
      end
      chk("abort no rsp", cnt, 0);
      // Contention: both requesters continuously valid.
      both = 0; nready = 0;
      for (int k = 0; k < 4; k++) begin
         acc_t[k] = -1; acc_p[k] = -1;
      end
      p0w = 1'b0; p0a = 18'h00100; p1w = 1'b0; p1a = 18'h00200; dat_rd = 16'h7777;
      p0v = 1'b1; p1v = 1'b1;
      for (int i = 0; i < 14; i++) begin
         #1;
         if (r0 && r1) both++;
         if (r0 || r1) begin
            if (nready < 4) begin
               acc_t[nready] = i; acc_p[nready] = r1 ? 1 : 0;
            end
            nready++;
         end
         @(negedge clk);
      end
      p0v = 1'b0; p1v = 1'b0;
      chk("contention double ready", both, 0);
      chk("contention ready count", nready, 4);
      for (int k = 0; k < 4; k++) chk($sformatf("contention grant %0d", k), acc_p[k], k % 2);
      for (int k = 1; k < 4; k++) chk($sformatf("contention spacing %0d", k), acc_t[k] - acc_t[k-1], 4);
      repeat (5) @(negedge clk);
      rd_len(0, 0, 18'h00042, 16'hC0DE);
      rd_len(1, 15, 18'h3F00F, 16'h5EED);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
